// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and default bit timing.
// Used by uart_tx and the planned uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // 12 MHz clk at 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  // Zero-extension of narrower words leaves the XOR unchanged; words must be <= 32 bits.
  function automatic logic calc_parity(input logic [31:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
// clear restarts the bit period so each new state gets a full period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining the TX FIFO: start bit, LSB-first data, optional parity, stop bit(s).
//
//   state     | meaning
//   ST_IDLE   | line high, waiting for fifo_empty low
//   ST_LOAD   | one cycle: capture head word, compute parity, pop FIFO
//   ST_START  | start bit (low) for one bit period
//   ST_DATA   | WIDTH data bits, LSB first
//   ST_PARITY | parity bit (only when PARITY != PARITY_NONE)
//   ST_STOP   | STOP_BITS high bit periods; last cycle chains to LOAD or IDLE
module uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH) + 1;

  uart_state_t      state, state_next;
  logic [WIDTH-1:0] shift, shift_next;
  logic [BW-1:0]    bit_cnt, bit_cnt_next;
  logic             par, par_next;
  logic             tx_next;
  logic             tick;
  logic             clear;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  assign fifo_rd = (state == ST_LOAD);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_cnt <= bit_cnt_next;
      par     <= par_next;
      tx      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    par_next     = par;
    tx_next      = 1'b1;
    clear        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        shift_next = fifo_data;
        par_next   = calc_parity(32'(fifo_data), PARITY);
        state_next = ST_START;
      end
      ST_START: begin
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == BW'(WIDTH - 1)) begin
            state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            shift_next   = shift >> 1;
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            state_next = fifo_empty ? ST_IDLE : ST_LOAD;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Every state starts with a fresh bit period and bit count.
    if (state_next != state) begin
      bit_cnt_next = '0;
      clear        = 1'b1;
    end
    if (state == ST_IDLE) clear = 1'b1;

    // tx is registered from the upcoming state so the pin never glitches.
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = par_next;
      default:   tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances (no parity, even, odd, two stop bits) with CLKS_PER_BIT=4,
// each fed by a small registered-output FIFO model.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int ND  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] f_data  [ND] = '{default: 8'h00};
  logic       f_empty [ND] = '{default: 1'b1};
  logic       f_rd    [ND];
  logic       tx      [ND];
  logic       busy    [ND];

  logic [7:0] mem    [ND][16];
  int         wr_ptr [ND] = '{default: 0};
  int         rd_ptr [ND] = '{default: 0};
  int         rd_cnt [ND] = '{default: 0};
  int         pop_err = 0;
  int         fifo_rp;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         d;
    logic [7:0] data;
    logic [11:0] seq;   // bit k = k-th transmitted bit (start first)
    int         nbits;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_data(f_data[0]), .fifo_empty(f_empty[0]),
    .fifo_rd(f_rd[0]), .tx(tx[0]), .busy(busy[0]));
  uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(PARITY_EVEN), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_data(f_data[1]), .fifo_empty(f_empty[1]),
    .fifo_rd(f_rd[1]), .tx(tx[1]), .busy(busy[1]));
  uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(PARITY_ODD), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .fifo_data(f_data[2]), .fifo_empty(f_empty[2]),
    .fifo_rd(f_rd[2]), .tx(tx[2]), .busy(busy[2]));
  uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(PARITY_NONE), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .fifo_data(f_data[3]), .fifo_empty(f_empty[3]),
    .fifo_rd(f_rd[3]), .tx(tx[3]), .busy(busy[3]));

  // FIFO model: dataout and empty are registered, as in the real TX FIFO.
  always @(posedge clk) begin
    for (int i = 0; i < ND; i++) begin
      fifo_rp = rd_ptr[i];
      if (f_rd[i] === 1'b1) begin
        if (f_empty[i] !== 1'b0) pop_err = pop_err + 1;
        fifo_rp = fifo_rp + 1;
        rd_cnt[i] <= rd_cnt[i] + 1;
      end
      rd_ptr[i]  <= fifo_rp;
      f_empty[i] <= (fifo_rp == wr_ptr[i]);
      f_data[i]  <= mem[i][fifo_rp % 16];
    end
  end

  task automatic push(input int d, input logic [7:0] v);
    mem[d][wr_ptr[d] % 16] = v;
    wr_ptr[d] = wr_ptr[d] + 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns positioned at the negedge of the LOAD cycle.
  task automatic wait_load(input int d, input int exp_lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (f_rd[d] !== 1'b1 && n < 200);
    check($sformatf("load_seen dut%0d", d), 32'(f_rd[d]), 32'd1);
    if (exp_lat >= 0) check($sformatf("load_latency dut%0d", d), n, exp_lat);
  endtask

  task automatic run_frame(input int d, input logic [11:0] seq, input int nbits, input string name);
    int   r0;
    logic got;
    logic busy_ok;
    r0 = rd_cnt[d];
    busy_ok = (busy[d] === 1'b1);
    for (int k = 0; k < nbits; k++) begin
      got = seq[k];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (tx[d] !== seq[k] && got === seq[k]) got = tx[d];
        if (busy[d] !== 1'b1 || f_rd[d] !== 1'b0) busy_ok = 1'b0;
      end
      check($sformatf("%s bit%0d", name, k), 32'(got), 32'(seq[k]));
    end
    check($sformatf("%s busy_no_extra_rd", name), 32'(busy_ok), 32'd1);
    check($sformatf("%s pops", name), rd_cnt[d] - r0, 32'd1);
  endtask

  task automatic check_idle(input int d, input string name);
    @(negedge clk);
    check(name, {29'd0, tx[d], busy[d], f_rd[d]}, 32'b100);
  endtask

  initial begin
    int r0;

    vecs[0] = '{d: 0, data: 8'hA5, seq: 12'h34A, nbits: 10};
    vecs[1] = '{d: 1, data: 8'h07, seq: 12'h60E, nbits: 11};
    vecs[2] = '{d: 2, data: 8'h07, seq: 12'h40E, nbits: 11};
    vecs[3] = '{d: 2, data: 8'h00, seq: 12'h600, nbits: 11};
    vecs[4] = '{d: 3, data: 8'hFF, seq: 12'h7FE, nbits: 11};
    vecs[5] = '{d: 1, data: 8'h00, seq: 12'h400, nbits: 11};

    // Reset held with a word waiting in the FIFO.
    rst = 1'b0;
    push(0, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("reset_hold%0d", i), {29'd0, tx[0], busy[0], f_rd[0]}, 32'b100);
    end
    rst = 1'b1;
    wait_load(0, 1);
    run_frame(0, 12'h278, 10, "after_reset_3C");
    check_idle(0, "after_reset_idle");

    for (int v = 0; v < 6; v++) begin
      push(vecs[v].d, vecs[v].data);
      wait_load(vecs[v].d, 2);
      run_frame(vecs[v].d, vecs[v].seq, vecs[v].nbits, $sformatf("vec%0d", v));
      check_idle(vecs[v].d, $sformatf("vec%0d_idle", v));
    end

    // Back-to-back frames: one LOAD cycle (line high, busy high) between frames.
    push(0, 8'h01);
    push(0, 8'h02);
    push(0, 8'h03);
    wait_load(0, 2);
    run_frame(0, 12'h202, 10, "b2b_01");
    @(negedge clk);
    check("b2b_gap1", {29'd0, tx[0], busy[0], f_rd[0]}, 32'b111);
    run_frame(0, 12'h204, 10, "b2b_02");
    @(negedge clk);
    check("b2b_gap2", {29'd0, tx[0], busy[0], f_rd[0]}, 32'b111);
    run_frame(0, 12'h206, 10, "b2b_03");
    check_idle(0, "b2b_idle");
    check("b2b_fifo_empty", 32'(f_empty[0]), 32'd1);
    check("b2b_fifo_drained", rd_ptr[0], wr_ptr[0]);

    // Reset during data bit 3 of 0x55.
    push(0, 8'h55);
    wait_load(0, 2);
    r0 = rd_cnt[0];
    repeat (18) @(negedge clk);
    check("mid_bit3_before_reset", {29'd0, tx[0], busy[0], f_rd[0]}, 32'b010);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mid_reset%0d", i), {29'd0, tx[0], busy[0], f_rd[0]}, 32'b100);
    end
    rst = 1'b1;
    check("mid_reset_pops", rd_cnt[0] - r0, 32'd1);
    check_idle(0, "mid_reset_released_idle");
    push(0, 8'hA5);
    wait_load(0, 2);
    run_frame(0, 12'h34A, 10, "post_reset_A5");
    check_idle(0, "post_reset_idle");

    check("pop_while_empty", pop_err, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
